// File: rtl/hpi_pkg.sv
// Shared register map and status-word layout for the HPI target model.
package hpi_pkg;

   localparam int unsigned HPI_DW = 16;

   typedef enum logic [1:0] {
      HPI_DATA    = 2'd0,
      HPI_MAILBOX = 2'd1,
      HPI_ADDRESS = 2'd2,
      HPI_STATUS  = 2'd3
   } hpi_reg_e;

   localparam int unsigned ST_MBX_OUT = 0;
   localparam int unsigned ST_MBX_IN  = 1;
   localparam int unsigned ST_OVERRUN = 2;

   // Assemble the host-visible STATUS word.
   function automatic logic [HPI_DW-1:0] status_word(input logic overrun,
                                                     input logic mbx_in_valid,
                                                     input logic mbx_out_pend);
      logic [HPI_DW-1:0] w;
      w             = '0;
      w[ST_OVERRUN] = overrun;
      w[ST_MBX_IN]  = mbx_in_valid;
      w[ST_MBX_OUT] = mbx_out_pend;
      return w;
   endfunction

endpackage

// File: rtl/hpi_strobe_sync.sv
// Registers the HPI pins once and turns the strobes into one-cycle access events.
module hpi_strobe_sync
   import hpi_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        addr_pin,
   input  logic [HPI_DW-1:0] data_pin,
   input  logic              rd_n_pin,
   input  logic              wr_n_pin,
   input  logic              cs_n_pin,
   output logic              rd_evt,
   output logic              wr_evt,
   output logic              rd_act,
   output hpi_reg_e          addr,
   output logic [HPI_DW-1:0] data
);

   logic              rd_act_q, rd_act_d;
   logic              wr_act_q, wr_act_d;
   logic              rd_evt_q, rd_evt_d;
   logic              wr_evt_q, wr_evt_d;
   hpi_reg_e          addr_q, addr_d;
   logic [HPI_DW-1:0] data_q, data_d;

   // Write strobe always wins over a concurrent read strobe.
   always_comb begin
      wr_act_d = ~cs_n_pin & ~wr_n_pin;
      rd_act_d = ~cs_n_pin & ~rd_n_pin & wr_n_pin;
      wr_evt_d = wr_act_d & ~wr_act_q;
      rd_evt_d = rd_act_d & ~rd_act_q;
      addr_d   = hpi_reg_e'(addr_pin);
      data_d   = data_pin;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_act_q <= 1'b0;
         wr_act_q <= 1'b0;
         rd_evt_q <= 1'b0;
         wr_evt_q <= 1'b0;
         addr_q   <= HPI_DATA;
         data_q   <= '0;
      end else begin
         rd_act_q <= rd_act_d;
         wr_act_q <= wr_act_d;
         rd_evt_q <= rd_evt_d;
         wr_evt_q <= wr_evt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   assign rd_evt = rd_evt_q;
   assign wr_evt = wr_evt_q;
   assign rd_act = rd_act_q;
   assign addr   = addr_q;
   assign data   = data_q;

endmodule

// File: rtl/hpi_target_model.sv
// Chip-side HPI responder: word memory, auto-incrementing pointer, mailboxes, status.
module hpi_target_model
   import hpi_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned MEM_AW    = $clog2(MEM_WORDS)
) (
   input  logic              Clk,
   input  logic              Reset_N,
   input  logic [1:0]        OTG_ADDR,
   inout  wire  [HPI_DW-1:0] OTG_DATA,
   input  logic              OTG_RD_N,
   input  logic              OTG_WR_N,
   input  logic              OTG_CS_N,
   output logic              OTG_INT,
   output logic [HPI_DW-1:0] mbx_in_data,
   output logic              mbx_in_valid,
   input  logic              mbx_in_ack,
   input  logic [HPI_DW-1:0] mbx_out_data,
   input  logic              mbx_out_load,
   output logic              mbx_out_busy
);

   logic              rd_evt, wr_evt, rd_act;
   hpi_reg_e          s_addr;
   logic [HPI_DW-1:0] s_data;

   hpi_strobe_sync u_sync (
      .clk      (Clk),
      .rst_n    (Reset_N),
      .addr_pin (OTG_ADDR),
      .data_pin (OTG_DATA),
      .rd_n_pin (OTG_RD_N),
      .wr_n_pin (OTG_WR_N),
      .cs_n_pin (OTG_CS_N),
      .rd_evt   (rd_evt),
      .wr_evt   (wr_evt),
      .rd_act   (rd_act),
      .addr     (s_addr),
      .data     (s_data)
   );

   logic [HPI_DW-1:0] mem [MEM_WORDS];

   logic [HPI_DW-1:0] addr_ptr_q, addr_ptr_d;
   logic [HPI_DW-1:0] mbx_in_q, mbx_in_d;
   logic              mbx_in_valid_q, mbx_in_valid_d;
   logic [HPI_DW-1:0] mbx_out_q, mbx_out_d;
   logic              int_q, int_d;
   logic              overrun_q, overrun_d;
   logic [HPI_DW-1:0] rd_q, rd_d;
   logic              drive_q, drive_d;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_idx;

   // Host event decode plus local mailbox handshake; a host write beats a local ack.
   always_comb begin
      addr_ptr_d     = addr_ptr_q;
      mbx_in_d       = mbx_in_q;
      mbx_in_valid_d = mbx_in_valid_q;
      mbx_out_d      = mbx_out_q;
      int_d          = int_q;
      overrun_d      = overrun_q;
      rd_d           = rd_q;
      drive_d        = rd_act;
      mem_we         = 1'b0;
      mem_idx        = addr_ptr_q[MEM_AW:1];

      if (mbx_in_ack) mbx_in_valid_d = 1'b0;

      if (wr_evt) begin
         case (s_addr)
            HPI_DATA: begin
               mem_we     = 1'b1;
               addr_ptr_d = addr_ptr_q + HPI_DW'(2);
            end
            HPI_MAILBOX: begin
               if (mbx_in_valid_q && !mbx_in_ack) overrun_d = 1'b1;
               mbx_in_d       = s_data;
               mbx_in_valid_d = 1'b1;
            end
            HPI_ADDRESS: addr_ptr_d = s_data;
            HPI_STATUS:  if (s_data[ST_OVERRUN]) overrun_d = 1'b0;
            default: ;
         endcase
      end

      if (rd_evt) begin
         case (s_addr)
            HPI_DATA: begin
               rd_d       = mem[mem_idx];
               addr_ptr_d = addr_ptr_q + HPI_DW'(2);
            end
            HPI_MAILBOX: begin
               rd_d  = mbx_out_q;
               int_d = 1'b0;
            end
            HPI_ADDRESS: rd_d = addr_ptr_q;
            HPI_STATUS:  rd_d = status_word(overrun_q, mbx_in_valid_q, int_q);
            default: ;
         endcase
      end

      // A load in the same cycle as a host mailbox read re-arms the interrupt.
      if (mbx_out_load && !int_q) begin
         mbx_out_d = mbx_out_data;
         int_d     = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         addr_ptr_q     <= '0;
         mbx_in_q       <= '0;
         mbx_in_valid_q <= 1'b0;
         mbx_out_q      <= '0;
         int_q          <= 1'b0;
         overrun_q      <= 1'b0;
         rd_q           <= '0;
         drive_q        <= 1'b0;
      end else begin
         addr_ptr_q     <= addr_ptr_d;
         mbx_in_q       <= mbx_in_d;
         mbx_in_valid_q <= mbx_in_valid_d;
         mbx_out_q      <= mbx_out_d;
         int_q          <= int_d;
         overrun_q      <= overrun_d;
         rd_q           <= rd_d;
         drive_q        <= drive_d;
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge Clk) begin
      if (mem_we) mem[mem_idx] <= s_data;
   end

   assign OTG_DATA     = drive_q ? rd_q : {HPI_DW{1'bz}};
   assign OTG_INT      = int_q;
   assign mbx_out_busy = int_q;
   assign mbx_in_data  = mbx_in_q;
   assign mbx_in_valid = mbx_in_valid_q;

endmodule

// File: tb/tb_hpi_target_model.sv
// Randomized transaction-level bench for hpi_target_model with a behavioural register model.
module tb_hpi_target_model;
   import hpi_pkg::*;

   localparam int unsigned MEM_WORDS = 1024;

   logic        clk;
   logic        rst_n;
   logic [1:0]  otg_addr;
   tri   [15:0] otg_data;
   logic        rd_n, wr_n, cs_n;
   logic        otg_int;
   logic [15:0] mbx_in_data;
   logic        mbx_in_valid;
   logic        mbx_in_ack;
   logic [15:0] mbx_out_data;
   logic        mbx_out_load;
   logic        mbx_out_busy;
   logic [15:0] tb_drv;
   logic        tb_drv_en;
   logic        quiet;

   int n_vec = 0;
   int n_err = 0;

   assign otg_data = tb_drv_en ? tb_drv : 16'hzzzz;
   pullup (otg_data);

   hpi_target_model #(.MEM_WORDS(MEM_WORDS)) dut (
      .Clk          (clk),
      .Reset_N      (rst_n),
      .OTG_ADDR     (otg_addr),
      .OTG_DATA     (otg_data),
      .OTG_RD_N     (rd_n),
      .OTG_WR_N     (wr_n),
      .OTG_CS_N     (cs_n),
      .OTG_INT      (otg_int),
      .mbx_in_data  (mbx_in_data),
      .mbx_in_valid (mbx_in_valid),
      .mbx_in_ack   (mbx_in_ack),
      .mbx_out_data (mbx_out_data),
      .mbx_out_load (mbx_out_load),
      .mbx_out_busy (mbx_out_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   logic [15:0] m_mem [MEM_WORDS];
   logic [15:0] m_ptr, m_in, m_out;
   bit          m_valid, m_int, m_ovr;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = '0; m_in = '0; m_out = '0;
      m_valid = 0; m_int = 0; m_ovr = 0;
   endtask

   // One host access plus any coincident local ack/load, applied as a single transaction.
   task automatic model_apply(input bit rd, input logic [1:0] a, input logic [15:0] d,
                              input bit ack, input bit load, input logic [15:0] lv,
                              output logic [15:0] exp_rd);
      bit v0, i0, o0;
      int idx;
      v0 = m_valid; i0 = m_int; o0 = m_ovr;
      idx = (int'(m_ptr) / 2) % MEM_WORDS;
      exp_rd = '0;
      if (ack) m_valid = 0;
      if (!rd) begin
         case (a)
            2'd0: begin m_mem[idx] = d; m_ptr = m_ptr + 16'd2; end
            2'd1: begin
               if (v0 && !ack) m_ovr = 1;
               m_in = d; m_valid = 1;
            end
            2'd2: m_ptr = d;
            default: if (d[2]) m_ovr = 0;
         endcase
      end else begin
         case (a)
            2'd0: begin exp_rd = m_mem[idx]; m_ptr = m_ptr + 16'd2; end
            2'd1: begin exp_rd = m_out; m_int = 0; end
            2'd2: exp_rd = m_ptr;
            default: exp_rd = 16'(o0) * 16'd4 + 16'(v0) * 16'd2 + 16'(i0);
         endcase
      end
      if (load && !i0) begin m_out = lv; m_int = 1; end
   endtask

   // Pin-level host access; 'both' pulls RD_N and WR_N low together.
   task automatic host_access(input bit rd, input bit both, input logic [1:0] a,
                              input logic [15:0] d, input int hold, input bit ack,
                              input bit load, input logic [15:0] lv,
                              output logic [15:0] r, output logic [15:0] e);
      bit is_rd;
      is_rd = rd && !both;
      @(posedge clk); #1;
      quiet    = 0;
      otg_addr = a;
      cs_n     = 0;
      rd_n     = (rd || both) ? 1'b0 : 1'b1;
      wr_n     = is_rd ? 1'b1 : 1'b0;
      if (!is_rd) begin tb_drv = d; tb_drv_en = 1; end
      @(posedge clk); #1;
      if (ack) mbx_in_ack = 1;
      if (load) begin mbx_out_data = lv; mbx_out_load = 1; end
      @(posedge clk); #1;
      mbx_in_ack = 0; mbx_out_load = 0;
      model_apply(is_rd, a, d, ack, load, lv, e);
      r = otg_data;
      for (int i = 2; i <= hold; i++) begin
         if (is_rd) chk("rd_bus", otg_data, e);
         else if (both) chk("both_bus", otg_data, d);
         if (i < hold) begin @(posedge clk); #1; end
      end
      cs_n = 1; rd_n = 1; wr_n = 1; tb_drv_en = 0;
      repeat (2) @(posedge clk);
      #1 quiet = 1;
   endtask

   task automatic hwr(input logic [1:0] a, input logic [15:0] d);
      logic [15:0] r, e;
      host_access(1'b0, 1'b0, a, d, 2, 1'b0, 1'b0, 16'h0, r, e);
   endtask

   task automatic hrd(input logic [1:0] a, output logic [15:0] r, output logic [15:0] e);
      host_access(1'b1, 1'b0, a, 16'h0, 2, 1'b0, 1'b0, 16'h0, r, e);
   endtask

   task automatic local_load(input logic [15:0] v);
      @(posedge clk); #1;
      mbx_out_data = v; mbx_out_load = 1;
      @(posedge clk); #1;
      mbx_out_load = 0;
      if (!m_int) begin m_out = v; m_int = 1; end
   endtask

   task automatic local_ack();
      @(posedge clk); #1;
      mbx_in_ack = 1;
      @(posedge clk); #1;
      mbx_in_ack = 0;
      m_valid = 0;
   endtask

   // Idle-cycle checker against the model
   always @(negedge clk) begin
      if (quiet && rst_n) begin
         chk("otg_int", 16'(otg_int), 16'(m_int));
         chk("mbx_out_busy", 16'(mbx_out_busy), 16'(m_int));
         chk("mbx_in_valid", 16'(mbx_in_valid), 16'(m_valid));
         chk("mbx_in_data", mbx_in_data, m_in);
         chk("bus_idle", otg_data, 16'hFFFF);
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r, e;
      bit          rd, ack, load;
      int          op, hold;
      logic [1:0]  a;
      rst_n = 0; cs_n = 1; rd_n = 1; wr_n = 1; otg_addr = 2'd0;
      tb_drv = '0; tb_drv_en = 0; mbx_in_ack = 0; mbx_out_load = 0;
      mbx_out_data = '0; quiet = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_bus", otg_data, 16'hFFFF);
      chk("rst_int", 16'(otg_int), 16'h0);
      chk("rst_valid", 16'(mbx_in_valid), 16'h0);
      quiet = 1;
      hrd(HPI_ADDRESS, r, e); chk("rst_ptr", r, 16'h0000);
      hrd(HPI_STATUS, r, e);  chk("rst_status", r, 16'h0000);

      hwr(HPI_ADDRESS, 16'h0000);
      for (int i = 0; i < int'(MEM_WORDS); i++) hwr(HPI_DATA, 16'($urandom));

      // Pointer auto-increment and readback
      hwr(HPI_ADDRESS, 16'h0010);
      hwr(HPI_DATA, 16'hAAAA);
      hwr(HPI_DATA, 16'h5555);
      hwr(HPI_ADDRESS, 16'h0010);
      hrd(HPI_DATA, r, e);    chk("lit_rd0", r, 16'hAAAA); chk("mdl_rd0", e, 16'hAAAA);
      hrd(HPI_DATA, r, e);    chk("lit_rd1", r, 16'h5555);
      hrd(HPI_ADDRESS, r, e); chk("lit_ptr", r, 16'h0014); chk("mdl_ptr", e, 16'h0014);

      // Held write strobe produces a single event
      host_access(1'b0, 1'b0, HPI_DATA, 16'h7777, 5, 1'b0, 1'b0, 16'h0, r, e);
      hrd(HPI_ADDRESS, r, e); chk("hold_ptr", r, 16'h0016);
      hwr(HPI_ADDRESS, 16'h0014);
      hrd(HPI_DATA, r, e);    chk("hold_mem", r, 16'h7777);

      // Outbound mailbox
      local_load(16'h1234);
      @(negedge clk); chk("lit_int_set", 16'(otg_int), 16'h1);
      hrd(HPI_STATUS, r, e);  chk("lit_st_out", r, 16'h0001);
      hrd(HPI_MAILBOX, r, e); chk("lit_mbx_out", r, 16'h1234);
      @(negedge clk); chk("lit_int_clr", 16'(otg_int), 16'h0);
      hrd(HPI_STATUS, r, e);  chk("lit_st_clr", r, 16'h0000);

      // Inbound mailbox overrun
      hwr(HPI_MAILBOX, 16'hBEEF);
      hwr(HPI_MAILBOX, 16'hBEEF);
      @(negedge clk); chk("lit_mbx_in", mbx_in_data, 16'hBEEF);
      hrd(HPI_STATUS, r, e);  chk("lit_st_ovr", r, 16'h0006); chk("mdl_st_ovr", e, 16'h0006);
      hwr(HPI_STATUS, 16'h0004);
      local_ack();
      hrd(HPI_STATUS, r, e);  chk("lit_st_zero", r, 16'h0000);

      // All strobes low: a write, bus never driven by the target
      hwr(HPI_ADDRESS, 16'h0100);
      hrd(HPI_ADDRESS, r, e); chk("lit_ptr100", r, 16'h0100);
      host_access(1'b1, 1'b1, HPI_ADDRESS, 16'h0000, 3, 1'b0, 1'b0, 16'h0, r, e);
      hrd(HPI_ADDRESS, r, e); chk("lit_both_wr", r, 16'h0000);

      // Memory index aliasing
      hwr(HPI_ADDRESS, 16'(2 * MEM_WORDS + 4));
      hwr(HPI_DATA, 16'h0F0F);
      hwr(HPI_ADDRESS, 16'h0004);
      hrd(HPI_DATA, r, e);    chk("lit_wrap", r, 16'h0F0F);

      // Host mailbox read coinciding with a local load
      host_access(1'b1, 1'b0, HPI_MAILBOX, 16'h0, 2, 1'b0, 1'b1, 16'hCAFE, r, e);
      chk("lit_rd_ld_old", r, 16'h1234);
      @(negedge clk); chk("lit_rd_ld_int", 16'(otg_int), 16'h1);
      hrd(HPI_MAILBOX, r, e); chk("lit_rd_ld_new", r, 16'hCAFE);

      // Host mailbox write coinciding with a local ack
      hwr(HPI_MAILBOX, 16'h2222);
      host_access(1'b0, 1'b0, HPI_MAILBOX, 16'h1111, 2, 1'b1, 1'b0, 16'h0, r, e);
      hrd(HPI_STATUS, r, e);  chk("lit_wr_ack", r, 16'h0002);
      local_ack();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 7) begin
            rd   = (op >= 4);
            a    = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(2, 4));
            ack  = ($urandom_range(0, 5) == 0);
            load = ($urandom_range(0, 5) == 0);
            host_access(rd, 1'b0, a, 16'($urandom), hold, ack, load, 16'($urandom), r, e);
         end else if (op == 8) begin
            local_load(16'($urandom));
         end else begin
            local_ack();
         end
      end

      // Reset during a held read
      hwr(HPI_ADDRESS, 16'h0200);
      hwr(HPI_MAILBOX, 16'h3333);
      local_load(16'h4444);
      @(posedge clk); #1;
      quiet = 0; otg_addr = HPI_ADDRESS; cs_n = 0; rd_n = 0;
      repeat (3) @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("rst_mid_bus", otg_data, 16'hFFFF);
      chk("rst_mid_int", 16'(otg_int), 16'h0);
      chk("rst_mid_busy", 16'(mbx_out_busy), 16'h0);
      chk("rst_mid_valid", 16'(mbx_in_valid), 16'h0);
      chk("rst_mid_in", mbx_in_data, 16'h0000);
      model_reset();
      #1 cs_n = 1; rd_n = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1; quiet = 1;
      hrd(HPI_ADDRESS, r, e); chk("post_rst_ptr", r, 16'h0000);
      hrd(HPI_MAILBOX, r, e); chk("post_rst_mbx", r, 16'h0000);
      hwr(HPI_ADDRESS, 16'h0004);
      hrd(HPI_DATA, r, e);    chk("post_rst_mem", r, 16'h0F0F);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hpi_target_model.md
Name: hpi_target_model

Overview:
- Synthesizable responder for the four-register EZ-OTG HPI bus, presenting the target (chip) side of OTG_DATA/OTG_ADDR/OTG_RD_N/OTG_WR_N/OTG_CS_N/OTG_INT.
- Serves host accesses from an internal word memory, an auto-incrementing address pointer, a bidirectional mailbox and a status register.
- Placed on the far side of the FPGA HPI host interface in board-less simulation and loopback builds.
- A small local port lets on-chip "firmware" logic consume and post mailbox messages.

Parameters:
- MEM_WORDS, 1024, depth of the 16-bit memory; power of two.
- MEM_AW, $clog2(MEM_WORDS), word-index width.

Ports:
- Clk  in  1  system clock; all pins are sampled on its rising edge.
- Reset_N  in  1  asynchronous, active-low reset (board connects OTG_RST_N).
- OTG_ADDR  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- OTG_DATA  inout  16  HPI data bus; driven only during reads.
- OTG_RD_N  in  1  read strobe, active-low.
- OTG_WR_N  in  1  write strobe, active-low.
- OTG_CS_N  in  1  chip select, active-low.
- OTG_INT  out  1  high while an outbound mailbox message is pending.
- mbx_in_data  out  16  last mailbox word written by the host.
- mbx_in_valid  out  1  host mailbox word not yet acknowledged locally.
- mbx_in_ack  in  1  one-cycle pulse; clears mbx_in_valid.
- mbx_out_data  in  16  local word to post to the host.
- mbx_out_load  in  1  one-cycle pulse; posts mbx_out_data.
- mbx_out_busy  out  1  outbound mailbox pending (equals OTG_INT).

Behaviour:
- Reset (async, Reset_N low): addr_ptr=0, mbx_in=0, mbx_in_valid=0, mbx_out=0, OTG_INT=0, overrun=0, rd_q=0, OTG_DATA tri-state. Memory contents are not reset.
- Input sampling and strobe decode:
  - All HPI inputs pass through one register stage.
  - wr_act = ~cs & ~wr (sampled values).
  - rd_act = ~cs & ~rd & wr, so a write strobe always wins.
- Access event: fires on the first sampled cycle of wr_act or rd_act, by edge detection against the previous sample. A held strobe produces exactly one event. A new event requires the strobe to deassert for at least one sampled cycle.
- Write event, by sampled ADDR:
  - DATA: mem[addr_ptr[MEM_AW:1]] <= data; addr_ptr <= addr_ptr+2.
  - MAILBOX: mbx_in <= data; mbx_in_valid <= 1. If mbx_in_valid was already 1 and no ack arrives in the same cycle, overrun <= 1.
  - ADDRESS: addr_ptr <= data (byte address). Bit 0 is stored but ignored for indexing.
  - STATUS: a write with data bit2=1 clears overrun; all other bits are ignored.
- Read event, by sampled ADDR:
  - DATA: rd_q <= mem[index]; addr_ptr += 2.
  - MAILBOX: rd_q <= mbx_out; OTG_INT <= 0.
  - ADDRESS: rd_q <= addr_ptr.
  - STATUS: rd_q <= {13'b0, overrun, mbx_in_valid, OTG_INT}.
- Read timing:
  - rd_q is loaded in the event cycle. OTG_DATA drives rd_q from the following cycle for as long as rd_act holds.
  - The bus returns to Z on the first cycle after rd_act drops.
  - Read data is therefore valid 2 Clk after the pin strobe falls.
- Address pointer:
  - Increments modulo 2^16.
  - Memory index wraps modulo MEM_WORDS; out-of-range addresses alias.
- Local mailbox handshake:
  - mbx_in_ack clears mbx_in_valid. If a host mailbox write lands in the same cycle, the write wins and valid stays 1.
  - mbx_out_load with mbx_out_busy=0: mbx_out <= mbx_out_data; OTG_INT <= 1.
  - mbx_out_load while busy is ignored.
- Simultaneous host MAILBOX read and local load while not busy: the read returns the old mbx_out, the load is accepted, and OTG_INT ends at 1.
- Reset mid-access: the bus is released immediately and the pending event is lost.

Decomposition:
- Package hpi_pkg holds:
  - enum hpi_reg_e {HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3};
  - status bit positions ST_MBX_OUT=0, ST_MBX_IN=1, ST_OVERRUN=2.
- One sub-module, hpi_strobe_sync: input register stage plus edge detection, outputting rd_evt, wr_evt, rd_act, addr and data. The memory is an inferred array inside the top module.

Test Plan:
- Write ADDRESS=0x0010, then DATA 0xAAAA and 0x5555; write ADDRESS=0x0010 and read DATA twice -> returns 0xAAAA then 0x5555; ADDRESS reads 0x0014.
- Hold a DATA write strobe low for 5 cycles -> exactly one memory write; addr_ptr advances by 2 only.
- Pulse mbx_out_load with 0x1234 -> OTG_INT=1 and STATUS=0x0001; host reads MAILBOX -> 0x1234, OTG_INT=0 and STATUS=0x0000.
- Host writes MAILBOX 0xBEEF twice with no ack -> mbx_in_data=0xBEEF, STATUS=0x0006; STATUS write 0x0004 then mbx_in_ack -> STATUS=0x0000.
- Assert CS_N, RD_N and WR_N all low -> treated as a write and OTG_DATA is never driven. Set ADDRESS=2*MEM_WORDS+4 and write 0x0F0F -> mem[2]=0x0F0F (wrap).
- Drop Reset_N during a held read -> OTG_DATA is Z in the same cycle and all outputs take their reset values; the access after reset behaves normally.
